// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode constants, instruction classes and
// the XLEN-independent decoded-field payload.
package mips_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned CLS_W    = 3;

    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_REGIMM = 6'h01;
    localparam logic [OPCODE_W-1:0] OP_J      = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 6'h03;
    localparam logic [OPCODE_W-1:0] OP_BEQ    = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BGTZ   = 6'h07;
    localparam logic [OPCODE_W-1:0] OP_ADDI   = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 6'h0F;
    localparam logic [OPCODE_W-1:0] OP_LB     = 6'h20;
    localparam logic [OPCODE_W-1:0] OP_LW     = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_LHU    = 6'h25;
    localparam logic [OPCODE_W-1:0] OP_SB     = 6'h28;
    localparam logic [OPCODE_W-1:0] OP_SH     = 6'h29;
    localparam logic [OPCODE_W-1:0] OP_SW     = 6'h2B;

    typedef enum logic [CLS_W-1:0] {
        CLS_R    = 3'b000,
        CLS_J    = 3'b001,
        CLS_BR   = 3'b010,
        CLS_LD   = 3'b011,
        CLS_ST   = 3'b100,
        CLS_ALUI = 3'b101,
        CLS_NOP  = 3'b110,
        CLS_ILL  = 3'b111
    } cls_t;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    shamt;
        logic [FUNCT_W-1:0]  funct;
        cls_t                cls;
        logic                illegal;
    } fields_t;

    localparam int unsigned FIELDS_W = $bits(fields_t);

    // Raw field split; class and illegal are filled in by the classifier.
    function automatic fields_t split_instr(input logic [INSTR_W-1:0] instr);
        fields_t f;
        f.opcode  = instr[31:26];
        f.rs      = instr[25:21];
        f.rt      = instr[20:16];
        f.rd      = instr[15:11];
        f.shamt   = instr[10:6];
        f.funct   = instr[5:0];
        f.cls     = CLS_R;
        f.illegal = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and downstream-side handshake/bus of the decode stage.
// slave: the decode stage view. master: the surrounding pipeline / bench view.
interface decode_stage_if
    import mips_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [INSTR_W-1:0]  in_instr;
    logic [XLEN-1:0]     in_pc;

    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    logic [OPCODE_W-1:0] out_opcode;
    logic [REG_W-1:0]    out_rs;
    logic [REG_W-1:0]    out_rt;
    logic [REG_W-1:0]    out_rd;
    logic [REG_W-1:0]    out_shamt;
    logic [FUNCT_W-1:0]  out_funct;
    logic [XLEN-1:0]     out_imm_sext;
    logic [XLEN-1:0]     out_imm_zext;
    logic [XLEN-1:0]     out_jtarget;
    cls_t                out_class;
    logic                out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_imm_sext, out_imm_zext, out_jtarget,
               out_class, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_imm_sext, out_imm_zext, out_jtarget,
               out_class, out_illegal
    );
endinterface

// File: rtl/instr_classify.sv
// Combinational instruction classifier.
// instr_i: raw instruction word. cls_o: class. illegal_o: opcode unsupported.
module instr_classify
    import mips_pkg::*;
#(
    parameter bit ILLEGAL_AS_NOP = 1'b0
) (
    input  logic [INSTR_W-1:0] instr_i,
    output cls_t               cls_o,
    output logic               illegal_o
);
    logic [OPCODE_W-1:0] op;
    cls_t                raw_c;

    assign op = instr_i[31:26];

    // All-zero word is the canonical NOP and wins over the R-type match.
    always_comb begin
        raw_c = CLS_ILL;
        if (instr_i == '0)                                          raw_c = CLS_NOP;
        else if (op == OP_RTYPE)                                    raw_c = CLS_R;
        else if (op == OP_J || op == OP_JAL)                        raw_c = CLS_J;
        else if (op == OP_REGIMM || (op >= OP_BEQ && op <= OP_BGTZ)) raw_c = CLS_BR;
        else if (op >= OP_ADDI && op <= OP_LUI)                     raw_c = CLS_ALUI;
        else if (op >= OP_LB && op <= OP_LHU)                       raw_c = CLS_LD;
        else if (op == OP_SB || op == OP_SH || op == OP_SW)         raw_c = CLS_ST;
    end

    always_comb begin
        cls_o     = raw_c;
        illegal_o = 1'b0;
        if (raw_c == CLS_ILL) begin
            if (ILLEGAL_AS_NOP) cls_o     = CLS_NOP;
            else                illegal_o = 1'b1;
        end
    end
endmodule

// File: rtl/decode_stage.sv
// Registered MIPS decode stage with a 2-entry skid buffer (main M, skid S).
// clk/reset: clock, async active-high reset. flush: drop all buffered work.
// bus: fetch handshake (in_*) and decoded-output handshake (out_*).
module decode_stage
    import mips_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter bit          ILLEGAL_AS_NOP = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    decode_stage_if.slave  bus
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm_sext;
        logic [XLEN-1:0] imm_zext;
        logic [XLEN-1:0] jtarget;
        fields_t         f;
    } entry_t;

    entry_t          dec_c;
    entry_t          m_q, m_d, s_q, s_d;
    logic            m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic [XLEN-1:0] pc4_c;
    logic [IMM_W-1:0] imm_c;
    cls_t            cls_c;
    logic            illegal_c;
    logic            accept_c, emit_c;

    instr_classify #(.ILLEGAL_AS_NOP(ILLEGAL_AS_NOP)) u_classify (
        .instr_i   (bus.in_instr),
        .cls_o     (cls_c),
        .illegal_o (illegal_c)
    );

    // Combinational decode of the incoming word.
    always_comb begin
        imm_c          = bus.in_instr[15:0];
        pc4_c          = bus.in_pc + XLEN'(4);
        dec_c.pc       = bus.in_pc;
        dec_c.imm_sext = {{(XLEN-IMM_W){imm_c[IMM_W-1]}}, imm_c};
        dec_c.imm_zext = XLEN'(imm_c);
        // Keep the region bits of pc+4, splice in the word-aligned index.
        dec_c.jtarget  = (pc4_c & ~XLEN'(32'h0FFF_FFFF))
                       | XLEN'({bus.in_instr[25:0], 2'b00});
        dec_c.f         = split_instr(bus.in_instr);
        dec_c.f.cls     = cls_c;
        dec_c.f.illegal = illegal_c;
    end

    assign accept_c = bus.in_valid & ~s_valid_q;
    assign emit_c   = m_valid_q & bus.out_ready;

    // Skid buffer next state; S is only ever drained into M, never emitted.
    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_d       = m_q;
        s_d       = s_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (s_valid_q) begin
            if (emit_c) begin
                m_d       = s_q;
                s_valid_d = 1'b0;
            end
        end else if (m_valid_q) begin
            if (accept_c && emit_c) begin
                m_d = dec_c;
            end else if (accept_c) begin
                s_d       = dec_c;
                s_valid_d = 1'b1;
            end else if (emit_c) begin
                m_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            m_d       = dec_c;
            m_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_q       <= '0;
            s_q       <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_q       <= m_d;
            s_q       <= s_d;
        end
    end

    assign bus.in_ready     = ~s_valid_q;
    assign bus.out_valid    = m_valid_q;
    assign bus.out_pc       = m_q.pc;
    assign bus.out_opcode   = m_q.f.opcode;
    assign bus.out_rs       = m_q.f.rs;
    assign bus.out_rt       = m_q.f.rt;
    assign bus.out_rd       = m_q.f.rd;
    assign bus.out_shamt    = m_q.f.shamt;
    assign bus.out_funct    = m_q.f.funct;
    assign bus.out_imm_sext = m_q.imm_sext;
    assign bus.out_imm_zext = m_q.imm_zext;
    assign bus.out_jtarget  = m_q.jtarget;
    assign bus.out_class    = m_q.f.cls;
    assign bus.out_illegal  = m_q.f.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (illegal->ILL and illegal->NOP) share
// one stimulus stream and are compared each cycle against a FIFO-level model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) ib0 ();
    decode_stage_if #(.XLEN(32)) ib1 ();

    assign ib0.in_valid = in_valid;  assign ib1.in_valid = in_valid;
    assign ib0.in_instr = in_instr;  assign ib1.in_instr = in_instr;
    assign ib0.in_pc    = in_pc;     assign ib1.in_pc    = in_pc;
    assign ib0.out_ready = out_ready; assign ib1.out_ready = out_ready;

    decode_stage #(.XLEN(32), .ILLEGAL_AS_NOP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .bus(ib0.slave));
    decode_stage #(.XLEN(32), .ILLEGAL_AS_NOP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .bus(ib1.slave));

    typedef struct packed {
        logic        valid, ready;
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [31:0] sext, zext, jt;
        logic [2:0]  cls;
        logic        illegal;
    } obs_t;

    typedef struct { logic [31:0] instr; logic [31:0] pc; } txn_t;

    obs_t o0, o1;
    always_comb begin
        o0.valid = ib0.out_valid; o0.ready = ib0.in_ready; o0.pc = ib0.out_pc;
        o0.opcode = ib0.out_opcode; o0.rs = ib0.out_rs; o0.rt = ib0.out_rt;
        o0.rd = ib0.out_rd; o0.shamt = ib0.out_shamt; o0.funct = ib0.out_funct;
        o0.sext = ib0.out_imm_sext; o0.zext = ib0.out_imm_zext; o0.jt = ib0.out_jtarget;
        o0.cls = ib0.out_class; o0.illegal = ib0.out_illegal;
        o1.valid = ib1.out_valid; o1.ready = ib1.in_ready; o1.pc = ib1.out_pc;
        o1.opcode = ib1.out_opcode; o1.rs = ib1.out_rs; o1.rt = ib1.out_rt;
        o1.rd = ib1.out_rd; o1.shamt = ib1.out_shamt; o1.funct = ib1.out_funct;
        o1.sext = ib1.out_imm_sext; o1.zext = ib1.out_imm_zext; o1.jt = ib1.out_jtarget;
        o1.cls = ib1.out_class; o1.illegal = ib1.out_illegal;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Class from the opcode table; the zero word is NOP before anything else.
    function automatic logic [2:0] exp_class(input logic [31:0] w, input bit nop_ill);
        logic [5:0] op;
        op = w[31:26];
        if (w == 32'h0) return 3'd6;
        case (op)
            6'h00:                                    return 3'd0;
            6'h02, 6'h03:                             return 3'd1;
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07:        return 3'd2;
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25: return 3'd3;
            6'h28, 6'h29, 6'h2B:                      return 3'd4;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F:               return 3'd5;
            default:                                  return nop_ill ? 3'd6 : 3'd7;
        endcase
    endfunction

    task automatic check_obs(input string tag, input obs_t o, input bit nop_ill, input txn_t t);
        logic [31:0] imm, sext, pc4, jt;
        logic [2:0]  cls;
        imm  = {16'h0, t.instr[15:0]};
        sext = (imm >= 32'h8000) ? (imm | 32'hFFFF_0000) : imm;
        pc4  = t.pc + 32'd4;
        jt   = (pc4 & 32'hF000_0000) + ({6'h0, t.instr[25:0]} * 32'd4);
        cls  = exp_class(t.instr, nop_ill);
        chk({tag, "_pc"},      o.pc,      t.pc);
        chk({tag, "_opcode"},  o.opcode,  t.instr >> 26);
        chk({tag, "_rs"},      o.rs,      (t.instr >> 21) & 32'h1F);
        chk({tag, "_rt"},      o.rt,      (t.instr >> 16) & 32'h1F);
        chk({tag, "_rd"},      o.rd,      (t.instr >> 11) & 32'h1F);
        chk({tag, "_shamt"},   o.shamt,   (t.instr >> 6) & 32'h1F);
        chk({tag, "_funct"},   o.funct,   t.instr & 32'h3F);
        chk({tag, "_sext"},    o.sext,    sext);
        chk({tag, "_zext"},    o.zext,    imm);
        chk({tag, "_jtarget"}, o.jt,      jt);
        chk({tag, "_class"},   o.cls,     cls);
        chk({tag, "_illegal"}, o.illegal, (cls == 3'd7));
    endtask

    // Reference: a 2-deep FIFO; pop on out_ready, push when not full, flush empties.
    txn_t q[$];
    always @(posedge clk or posedge reset) begin
        if (reset) q.delete();
        else begin
            bit pop, push;
            txn_t t;
            pop  = out_ready && (q.size() > 0);
            push = in_valid && (q.size() < 2);
            t.instr = in_instr; t.pc = in_pc;
            if (flush) q.delete();
            else begin
                if (pop)  void'(q.pop_front());
                if (push) q.push_back(t);
            end
        end
    end

    bit          log_en = 1'b0;
    logic [31:0] emitted[$];

    always @(negedge clk) begin
        if (!reset) begin
            chk("dut0_in_ready",  o0.ready, q.size() < 2);
            chk("dut0_out_valid", o0.valid, q.size() > 0);
            chk("dut1_in_ready",  o1.ready, q.size() < 2);
            chk("dut1_out_valid", o1.valid, q.size() > 0);
            if (q.size() > 0) begin
                check_obs("dut0", o0, 1'b0, q[0]);
                check_obs("dut1", o1, 1'b1, q[0]);
            end
            if (log_en && o0.valid && out_ready) emitted.push_back(o0.pc);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v; in_instr = ins; in_pc = pc;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [0:15];
        logic [31:0] w;
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h0F,
                6'h20, 6'h23, 6'h25, 6'h28, 6'h2B, 6'h3F, 6'h10, 6'h2A};
        if ($urandom_range(0, 15) == 0) return 32'h0;
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[31:26] = ops[$urandom_range(0, 15)];
        return w;
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", o0.valid, 1'b0);
        chk("rst_in_ready",  o0.ready, 1'b1);
        chk("rst_class",     o0.cls,   3'd0);
        chk("rst_pc",        o0.pc,    32'h0);
        step(); reset = 1'b0;

        // lw
        out_ready = 1'b1;
        drive(1'b1, 32'h8C43_0004, 32'h0040_0000);
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("lw_valid", o0.valid, 1'b1);
        chk("lw_class", o0.cls,   3'b011);
        chk("lw_rs",    o0.rs,    5'd2);
        chk("lw_rt",    o0.rt,    5'd3);
        chk("lw_sext",  o0.sext,  32'h0000_0004);
        chk("lw_pc",    o0.pc,    32'h0040_0000);
        step();

        // beq then j, back to back
        drive(1'b1, 32'h1000_FFFF, 32'h0040_000C);
        step();
        drive(1'b1, 32'h0810_0003, 32'h0040_0010);
        @(negedge clk);
        chk("beq_sext",  o0.sext, 32'hFFFF_FFFF);
        chk("beq_zext",  o0.zext, 32'h0000_FFFF);
        chk("beq_class", o0.cls,  3'b010);
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("j_jtarget", o0.jt,  32'h0040_000C);
        chk("j_class",   o0.cls, 3'b001);
        step(); step();

        // back-pressure: A, B fill the buffer, C stalls
        out_ready = 1'b0; emitted.delete(); log_en = 1'b1;
        drive(1'b1, 32'h2001_0001, 32'h0000_1000);
        @(negedge clk); chk("bp_ready_a", o0.ready, 1'b1);
        step();
        drive(1'b1, 32'hAC22_0008, 32'h0000_1004);
        @(negedge clk); chk("bp_ready_b", o0.ready, 1'b1);
        step();
        drive(1'b1, 32'h0022_1820, 32'h0000_1008);
        @(negedge clk); chk("bp_ready_c", o0.ready, 1'b0);
        chk("bp_head_a", o0.pc, 32'h0000_1000);
        step();
        @(negedge clk); chk("bp_hold_a", o0.pc, 32'h0000_1000);
        step(); out_ready = 1'b1;
        step(); step(); in_valid = 1'b0;
        step(); step(); step();
        log_en = 1'b0;
        chk("bp_count", emitted.size(), 3);
        if (emitted.size() == 3) begin
            chk("bp_order0", emitted[0], 32'h0000_1000);
            chk("bp_order1", emitted[1], 32'h0000_1004);
            chk("bp_order2", emitted[2], 32'h0000_1008);
        end

        // flush while FULL with a pending input
        out_ready = 1'b0;
        drive(1'b1, 32'h2002_0005, 32'h0000_2000); step();
        drive(1'b1, 32'h2003_0006, 32'h0000_2004); step();
        drive(1'b1, 32'h2004_0007, 32'h0000_2008); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_full_valid", o0.valid, 1'b0);
        chk("flush_full_ready", o0.ready, 1'b1);
        step();
        // flush in the same cycle an instruction is accepted
        drive(1'b1, 32'h2005_0008, 32'h0000_3000); step();
        drive(1'b1, 32'h2006_0009, 32'h0000_3004); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_acc_valid", o0.valid, 1'b0);
        out_ready = 1'b1; step(); step();

        // illegal opcode and the zero word
        drive(1'b1, 32'hFC00_0000, 32'h0000_4000); step();
        drive(1'b1, 32'h0000_0000, 32'h0000_4004);
        @(negedge clk);
        chk("ill_class0",   o0.cls,     3'b111);
        chk("ill_illegal0", o0.illegal, 1'b1);
        chk("ill_class1",   o1.cls,     3'b110);
        chk("ill_illegal1", o1.illegal, 1'b0);
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("zero_class0",   o0.cls,     3'b110);
        chk("zero_illegal0", o0.illegal, 1'b0);
        chk("zero_class1",   o1.cls,     3'b110);
        step();

        // reset while FULL and stalled
        out_ready = 1'b0;
        drive(1'b1, 32'h8C43_0004, 32'h0000_5000); step();
        drive(1'b1, 32'h0810_0003, 32'h0000_5004); step();
        drive(1'b1, 32'h1000_FFFF, 32'h0000_5008); step();
        reset = 1'b1; #1;
        chk("mrst_valid",   o0.valid,   1'b0);
        chk("mrst_ready",   o0.ready,   1'b1);
        chk("mrst_pc",      o0.pc,      32'h0);
        chk("mrst_class",   o0.cls,     3'd0);
        chk("mrst_sext",    o0.sext,    32'h0);
        chk("mrst_jt",      o0.jt,      32'h0);
        chk("mrst_illegal", o0.illegal, 1'b0);
        in_valid = 1'b0;
        step(); step(); reset = 1'b0;

        // randomized traffic
        repeat (4000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_instr  = rand_instr();
            in_pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, flow-controlled instruction decode stage for the MIPS pipeline, sitting between the fetch stage and register-file read / control.
- Splits a 32-bit instruction into its fields and sign/zero-extends the immediate to XLEN.
- Computes the jump target and classifies the instruction.
- Provides a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops or duplicates an instruction.

Parameters:
- XLEN, 32, datapath width for PC, extended immediates and jump target. Must be >= 32.
- ILLEGAL_AS_NOP, 0. 1: illegal opcodes are emitted as class NOP with out_illegal=0. 0: emitted as class ILL with out_illegal=1.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  discard all buffered instructions (branch/exception redirect)
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  raw instruction word
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  decoded instruction available
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  PC of the decoded instruction
- out_opcode  out  6  bits 31:26
- out_rs / out_rt / out_rd  out  5 each  bits 25:21 / 20:16 / 15:11
- out_shamt  out  5  bits 10:6
- out_funct  out  6  bits 5:0
- out_imm_sext  out  XLEN  bits 15:0 sign-extended
- out_imm_zext  out  XLEN  bits 15:0 zero-extended
- out_jtarget  out  XLEN  {(pc+4)[XLEN-1:28], instr[25:0], 2'b00}
- out_class  out  3  instruction class (see Behaviour)
- out_illegal  out  1  opcode not in the supported set

Behaviour:
- Storage: main entry M and skid entry S, each holding a valid bit plus the decoded payload. Decode is combinational on in_instr and is registered on acceptance.
- Accept: in_valid & in_ready. Emit: out_valid & out_ready.
- out_valid = M.valid. Outputs always reflect M.
- in_ready = !S.valid. It is a registered term only, with no combinational path from out_ready.
- Latency: an accepted instruction appears on the outputs the next cycle when M is empty or draining. Sustained throughput is 1 per cycle with out_ready=1.
- State encoding {M.valid, S.valid}:
  - EMPTY(00): accept -> ONE.
  - ONE(10): accept & emit -> ONE (M reloaded). Accept & !emit -> FULL (new item into S). Emit & !accept -> EMPTY.
  - FULL(11): in_ready=0. Emit -> ONE with S moved into M and S cleared.
- Ordering is strictly FIFO; S never bypasses M.
- flush: synchronous, highest priority. Next cycle M.valid=S.valid=0, and any instruction accepted in the flush cycle is discarded. in_ready is still evaluated from the current S.valid, so the producer sees a normal handshake.
- Reset: asynchronous. M.valid=S.valid=0, in_ready=1 after reset, all payload registers 0 (out_class=R, out_illegal=0). Reset mid-transfer drops everything.
- Classes (out_class):
  - 000 R: op 0x00
  - 001 J: op 0x02, 0x03
  - 010 BR: op 0x01, 0x04–0x07
  - 011 LD: op 0x20–0x25
  - 100 ST: op 0x28, 0x29, 0x2B
  - 101 ALUI: op 0x08–0x0F
  - 110 NOP: instr == 0, which takes priority over R
  - 111 ILL: all other opcodes
- out_illegal = (class==ILL). With ILLEGAL_AS_NOP=1, class ILL is replaced by NOP and out_illegal=0.
- Width rules:
  - pc+4 computed modulo 2^XLEN.
  - The jump target upper field is XLEN-28 bits of pc+4.
  - Sign extension replicates bit 15 across XLEN-16 bits.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_LW, OP_SW, ...)
  - class encodings CLS_R..CLS_ILL
  - decoded-payload struct/width constant
- Natural sub-module: instr_classify. Combinational: opcode + instr -> class, illegal. Reused later by the hazard unit.
- The skid buffer stays inline in decode_stage.

Test Plan:
- Reset asserted mid-stream with out_ready=0 and FULL state -> out_valid=0, in_ready=1 immediately, all outputs 0.
- Stream instr 0x8C430004 (lw), pc=0x00400000, out_ready=1 -> 1 cycle later: class=011, rs=2, rt=3, imm_sext=0x00000004, out_pc=0x00400000.
- Stream 0x1000FFFF (beq), then 0x08100003 (j) at pc=0x00400010:
  - beq -> imm_sext=0xFFFFFFFF, imm_zext=0x0000FFFF, class=010.
  - j -> jtarget=0x0040000C, class=001.
- Back-pressure: push 3 instrs A,B,C back-to-back with out_ready=0 -> in_ready drops after B and C stalls. Release out_ready -> A,B,C emitted in order, no loss or duplication.
- flush asserted while FULL and in_valid=1 -> next cycle out_valid=0. The flushed-cycle instruction never appears.
- Opcode 0x3F -> class=111, illegal=1. Rerun with ILLEGAL_AS_NOP=1 -> class=110, illegal=0. Word 0x00000000 -> class=110.
